linear_layer_start_fifo_srl: RTL and testbench

//  - SRL-based start/stream FIFO controller between a producer task and its consumer

---
 rtl/linear_layer_start_fifo_srl_pkg.sv | 6 +
 rtl/linear_layer_start_fifo_srl_if.sv | 24 ++
 rtl/linear_layer_start_fifo_srl_core.sv | 21 ++
 rtl/linear_layer_start_fifo_srl.sv | 72 +++++++
 tb/tb_linear_layer_start_fifo_srl.sv | 123 ++++++++++++
 5 files changed

// File: rtl/linear_layer_start_fifo_srl_pkg.sv
// linear_layer_fifo_pkg: shared sizing helpers for the start-token SRL FIFO.
package linear_layer_fifo_pkg;
   function automatic int FIFO_ADDR_W(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction
endpackage

// File: rtl/linear_layer_start_fifo_srl_if.sv
// linear_layer_start_fifo_srl_if: producer/consumer handshake bundle of the start FIFO.
interface linear_layer_start_fifo_srl_if #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1
);
   logic                  if_write_ce;
   logic                  if_write;
   logic [DATA_WIDTH-1:0] if_din;
   logic                  if_full_n;
   logic                  if_read_ce;
   logic                  if_read;
   logic [DATA_WIDTH-1:0] if_dout;
   logic                  if_empty_n;
   logic [ADDR_WIDTH:0]   if_num_data_valid;
   logic [ADDR_WIDTH:0]   if_fifo_cap;
   modport master (
      output if_write_ce, if_write, if_din, if_read_ce, if_read,
      input  if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
   );
   modport slave (
      input  if_write_ce, if_write, if_din, if_read_ce, if_read,
      output if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
   );
endinterface

// File: rtl/linear_layer_start_fifo_srl_core.sv
// start_fifo_srl_core: DEPTH-slot shift register; new word enters slot 0, async read by addr.
module start_fifo_srl_core #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
      end
   end
   assign dout = r_mem[addr];
endmodule

// File: rtl/linear_layer_start_fifo_srl.sv
// linear_layer_start_fifo_srl: FWFT start FIFO controller; count/pointer/flags over an SRL core.
module linear_layer_start_fifo_srl
   import linear_layer_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 2,
   parameter int ADDR_WIDTH = FIFO_ADDR_W(DEPTH)
) (
   input  logic ap_clk,
   input  logic ap_rst_n,
   linear_layer_start_fifo_srl_if.slave s_fifo
);
   typedef logic [ADDR_WIDTH:0] cnt_t;
   cnt_t                  r_count, w_count_nxt;
   logic [ADDR_WIDTH-1:0] r_rd_ptr, w_rd_ptr_nxt;
   logic                  r_empty_n, r_full_n, w_empty_n_nxt, w_full_n_nxt;
   logic                  w_push, w_pop;
   always_comb begin
      w_push        = s_fifo.if_write_ce & s_fifo.if_write & r_full_n;
      w_pop         = s_fifo.if_read_ce & s_fifo.if_read & r_empty_n;
      w_count_nxt   = r_count;
      w_rd_ptr_nxt  = r_rd_ptr;
      w_empty_n_nxt = r_empty_n;
      w_full_n_nxt  = r_full_n;
      // push & pop together: the shift alone moves the head into rd_ptr
      if (w_push && !w_pop) begin
         w_count_nxt   = r_count + 1'b1;
         w_rd_ptr_nxt  = (r_count == '0) ? r_rd_ptr : r_rd_ptr + 1'b1;
         w_empty_n_nxt = 1'b1;
         w_full_n_nxt  = (r_count != cnt_t'(DEPTH - 1));
      end else if (w_pop && !w_push) begin
         w_count_nxt   = r_count - 1'b1;
         w_rd_ptr_nxt  = (r_count == cnt_t'(1)) ? r_rd_ptr : r_rd_ptr - 1'b1;
         w_full_n_nxt  = 1'b1;
         w_empty_n_nxt = (r_count != cnt_t'(1));
      end
   end
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_count   <= '0;
         r_rd_ptr  <= '0;
         r_empty_n <= 1'b0;
         r_full_n  <= 1'b1;
      end else begin
         r_count   <= w_count_nxt;
         r_rd_ptr  <= w_rd_ptr_nxt;
         r_empty_n <= w_empty_n_nxt;
         r_full_n  <= w_full_n_nxt;
      end
   end
   start_fifo_srl_core #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH     (DEPTH)
   ) u_core (
      .clk (ap_clk),
      .we  (w_push),
      .addr(r_rd_ptr),
      .din (s_fifo.if_din),
      .dout(s_fifo.if_dout)
   );
   assign s_fifo.if_full_n         = r_full_n;
   assign s_fifo.if_empty_n        = r_empty_n;
   assign s_fifo.if_num_data_valid = r_count;
   assign s_fifo.if_fifo_cap       = cnt_t'(DEPTH);
`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
      r_count <= cnt_t'(DEPTH) && !(w_push && r_count == cnt_t'(DEPTH)));
   a_no_underflow: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
      !(w_pop && r_count == '0));
`endif
endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
// tb_linear_layer_start_fifo_srl: vector table plus queue scoreboard for DEPTH=4 and DEPTH=1 FIFOs.
module tb_linear_layer_start_fifo_srl;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [7:0] q4[$];
   logic [7:0] q1[$];
   typedef struct {
      int         sel;
      logic       wce, w;
      logic [7:0] din;
      logic       rce, r;
      logic       en, fn;
      int         cnt;
   } vec_t;
   vec_t vecs[$];
   always #5 clk = ~clk;
   linear_layer_start_fifo_srl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) a ();
   linear_layer_start_fifo_srl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) b ();
   linear_layer_start_fifo_srl #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2)) dut4 (
      .ap_clk(clk), .ap_rst_n(rst_n), .s_fifo(a.slave));
   linear_layer_start_fifo_srl #(.DATA_WIDTH(8), .DEPTH(1), .ADDR_WIDTH(1)) dut1 (
      .ap_clk(clk), .ap_rst_n(rst_n), .s_fifo(b.slave));
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic add(input int sel, input logic wce, w, input logic [7:0] din,
                      input logic rce, r, input logic en, fn, input int cnt);
      vec_t v;
      v = '{sel, wce, w, din, rce, r, en, fn, cnt};
      vecs.push_back(v);
   endtask
   // drives one cycle; the queue model decides push/pop and checks the head on every pop
   task automatic step(input int sel, input logic wce, w, input logic [7:0] din, input logic rce, r);
      logic push, pop;
      logic [7:0] hd;
      a.if_write_ce = (sel == 0) & wce; a.if_write = (sel == 0) & w; a.if_din = din;
      a.if_read_ce  = (sel == 0) & rce; a.if_read  = (sel == 0) & r;
      b.if_write_ce = (sel == 1) & wce; b.if_write = (sel == 1) & w; b.if_din = din;
      b.if_read_ce  = (sel == 1) & rce; b.if_read  = (sel == 1) & r;
      if (sel == 0) begin
         push = wce && w && q4.size() < 4;
         pop  = rce && r && q4.size() > 0;
         if (pop) begin hd = q4.pop_front(); check("d4_pop_dout", a.if_dout, hd); end
         if (push) q4.push_back(din);
      end else begin
         push = wce && w && q1.size() < 1;
         pop  = rce && r && q1.size() > 0;
         if (pop) begin hd = q1.pop_front(); check("d1_pop_dout", b.if_dout, hd); end
         if (push) q1.push_back(din);
      end
      @(posedge clk); #1;
   endtask
   task automatic check_state(input string tag, input int sel, input logic en, fn, input int cnt);
      check({tag, "_empty_n"}, sel ? b.if_empty_n : a.if_empty_n, en);
      check({tag, "_full_n"}, sel ? b.if_full_n : a.if_full_n, fn);
      check({tag, "_count"}, sel ? 32'(b.if_num_data_valid) : 32'(a.if_num_data_valid), cnt);
   endtask
   initial begin
      rst_n = 1'b0;
      a.if_write_ce = 1'b1; a.if_write = 1'b1; a.if_din = 8'hEE;
      a.if_read_ce = 1'b0; a.if_read = 1'b0;
      b.if_write_ce = 1'b1; b.if_write = 1'b1; b.if_din = 8'hEE;
      b.if_read_ce = 1'b0; b.if_read = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_state("rst4", 0, 0, 1, 0);
      check_state("rst1", 1, 0, 1, 0);
      check("cap4", 32'(a.if_fifo_cap), 4);
      check("cap1", 32'(b.if_fifo_cap), 1);
      rst_n = 1'b1;
      step(0, 0, 0, 8'h00, 0, 0);
      check_state("post_rst4", 0, 0, 1, 0);
      check_state("post_rst1", 1, 0, 1, 0);
      // fill and drain
      add(0,1,1,8'h11,0,0, 1,1,1); add(0,1,1,8'h22,0,0, 1,1,2);
      add(0,1,1,8'h33,0,0, 1,1,3); add(0,1,1,8'h44,0,0, 1,0,4);
      add(0,0,0,8'h00,1,1, 1,1,3); add(0,0,0,8'h00,1,1, 1,1,2);
      add(0,0,0,8'h00,1,1, 1,1,1); add(0,0,0,8'h00,1,1, 0,1,0);
      // simultaneous push/pop at count 2
      add(0,1,1,8'hA0,0,0, 1,1,1); add(0,1,1,8'hA1,0,0, 1,1,2);
      add(0,1,1,8'hA2,1,1, 1,1,2); add(0,0,0,8'h00,1,1, 1,1,1);
      add(0,0,0,8'h00,1,1, 0,1,0);
      // full with write and read: only the pop happens
      add(0,1,1,8'h01,0,0, 1,1,1); add(0,1,1,8'h02,0,0, 1,1,2);
      add(0,1,1,8'h03,0,0, 1,1,3); add(0,1,1,8'h04,0,0, 1,0,4);
      add(0,1,1,8'h55,1,1, 1,1,3); add(0,0,0,8'h00,1,1, 1,1,2);
      add(0,0,0,8'h00,1,1, 1,1,1); add(0,0,0,8'h00,1,1, 0,1,0);
      // empty with write and read: plain push
      add(0,1,1,8'h77,1,1, 1,1,1); add(0,0,0,8'h00,1,1, 0,1,0);
      // clock-enable gating
      add(0,0,1,8'h99,0,0, 0,1,0); add(0,1,1,8'h05,0,0, 1,1,1);
      add(0,1,1,8'h06,0,0, 1,1,2); add(0,1,1,8'h07,0,0, 1,1,3);
      add(0,0,1,8'h88,0,1, 1,1,3);
      // DEPTH=1 instance
      add(1,1,1,8'h11,0,0, 1,0,1); add(1,1,1,8'h22,0,0, 1,0,1);
      add(1,0,0,8'h00,1,1, 0,1,0); add(1,1,1,8'h33,1,1, 1,0,1);
      add(1,1,1,8'h44,1,1, 0,1,0); add(1,0,0,8'h00,1,1, 0,1,0);
      foreach (vecs[i]) begin
         step(vecs[i].sel, vecs[i].wce, vecs[i].w, vecs[i].din, vecs[i].rce, vecs[i].r);
         check_state($sformatf("vec%0d", i), vecs[i].sel, vecs[i].en, vecs[i].fn, vecs[i].cnt);
      end
      // mid-operation reset with three words still held in the DEPTH=4 FIFO
      check_state("pre_midrst", 0, 1, 1, 3);
      rst_n = 1'b0;
      step(0, 0, 0, 8'h00, 0, 0);
      q4.delete();
      q1.delete();
      rst_n = 1'b1;
      check_state("midrst", 0, 0, 1, 0);
      step(0, 1, 1, 8'hC3, 0, 0);
      check_state("after_rst_push", 0, 1, 1, 1);
      step(0, 0, 0, 8'h00, 1, 1);
      check_state("after_rst_pop", 0, 0, 1, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
